// File: rtl/mux_sel_serializer.sv
// Sequencer for an 8:1 select mux: latches a word on `a` and walks `sel` across it one bit per enabled clock.
// Optional even-parity trailer beat is compiled in with SER_PARITY_EN.
module mux_sel_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int SEL_W    = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              step_en,
    output logic [DATA_W-1:0] a,
    output logic [SEL_W-1:0]  sel,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              parity_phase,
    output logic              done
);

    localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
    localparam logic [SEL_W-1:0] SEL_FINAL = MSB_FIRST ? '0 : SEL_W'(DATA_W - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] a_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              done_nxt;
    logic              at_final;

    assign at_final = (sel == SEL_FINAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            sel   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            sel   <= sel_nxt;
            done  <= done_nxt;
        end
    end

    // sel never wraps inside a word: the final index always exits SHIFT
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        sel_nxt   = sel;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    a_nxt     = load_data;
                    sel_nxt   = SEL_FIRST;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (step_en) begin
                    if (at_final) begin
`ifdef SER_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
`endif
                    end else if (MSB_FIRST) begin
                        sel_nxt = sel - SEL_W'(1);
                    end else begin
                        sel_nxt = sel + SEL_W'(1);
                    end
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (step_en) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign load_ready = (state == IDLE);
    assign ser_valid  = (state != IDLE);

`ifdef SER_PARITY_EN
    assign parity_phase = (state == PARITY);
    assign ser_last     = (state == PARITY);
    assign ser_bit      = parity_phase ? ^a : a[sel];
`else
    assign parity_phase = 1'b0;
    assign ser_last     = (state == SHIFT) && at_final;
    assign ser_bit      = a[sel];
`endif

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Scoreboard bench for mux_sel_serializer: an accept pushes the word's expected beats, a monitor pops them as beats are consumed.
module tb_mux_sel_serializer;
    localparam int DW  = 8;
    localparam int SW  = $clog2(DW);
    localparam bit MSB = 1'b0;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          step_en;
    logic [DW-1:0] a;
    logic [SW-1:0] sel;
    logic          ser_bit, ser_valid, ser_last, parity_phase, done;
    logic          y;

    mux_sel_serializer #(.DATA_W(DW), .MSB_FIRST(MSB)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .step_en(step_en), .a(a), .sel(sel),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_last(ser_last),
        .parity_phase(parity_phase), .done(done)
    );

    // the downstream 8:1 mux
    assign y = a[sel];

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [SW-1:0] sel;
        logic          b;
        logic          last;
        logic          par;
        logic          fin;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] model_a = '0;
    logic          model_busy = 1'b0;
    logic          exp_done = 1'b0;
    int            cyc = 0;
    int            acc_cnt = 0, acc_cyc = 0;
    int            done_cnt = 0, done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // expected beats of one word, straight from the serialization rules
    task automatic push_word(input logic [DW-1:0] w);
        beat_t bt;
        for (int i = 0; i < DW; i++) begin
            bt.sel  = MSB ? SW'(DW - 1 - i) : SW'(i);
            bt.b    = w[bt.sel];
            bt.last = (PAR == 0) && (i == DW - 1);
            bt.par  = 1'b0;
            bt.fin  = (PAR == 0) && (i == DW - 1);
            exp_q.push_back(bt);
        end
        if (PAR != 0) begin
            bt.sel  = MSB ? SW'(0) : SW'(DW - 1);
            bt.b    = ^w;
            bt.last = 1'b1;
            bt.par  = 1'b1;
            bt.fin  = 1'b1;
            exp_q.push_back(bt);
        end
    endtask

    always @(negedge clk) begin
        beat_t bt;
        logic  fin;
        if (rst) begin
            exp_q.delete();
            model_a    = '0;
            model_busy = 1'b0;
            exp_done   = 1'b0;
        end else begin
            chk("done", done, exp_done);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            chk("a_held", a, model_a);
            chk("load_ready", load_ready, !model_busy);
            chk("ser_valid", ser_valid, model_busy);
            fin = 1'b0;
            if (load_valid && load_ready) begin
                push_word(load_data);
                model_a    = load_data;
                model_busy = 1'b1;
                acc_cnt++;
                acc_cyc = cyc;
            end else if (ser_valid && step_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    bt = exp_q.pop_front();
                    chk("sel", sel, bt.sel);
                    chk("ser_bit", ser_bit, bt.b);
                    chk("ser_last", ser_last, bt.last);
                    chk("parity_phase", parity_phase, bt.par);
                    if (!bt.par) chk("mux_y", y, bt.b);
                    fin = bt.fin;
                    if (fin) model_busy = 1'b0;
                end
            end
            exp_done = fin;
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!(load_ready && !ser_valid) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 500) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        while (done_cnt == base && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 500) chk("wait_done_timeout", 1, 0);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int stall_at, input int stall_n, output int lat);
        int ba, bd, k;
        wait_idle();
        ba = acc_cnt;
        bd = done_cnt;
        load_data  = w;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("accepted", acc_cnt, ba + 1);
        if (stall_n > 0) begin
            k = 0;
            while (!(ser_valid && sel == SW'(stall_at)) && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            if (k >= 100) chk("stall_wait_timeout", 1, 0);
            step_en = 1'b0;
            repeat (stall_n) @(posedge clk);
            #1;
            chk("stall_sel_hold", sel, stall_at);
            chk("stall_a_hold", a, w);
            step_en = 1'b1;
        end
        wait_done(bd);
        lat = done_cyc - acc_cyc;
    endtask

`ifdef SER_PARITY_EN
    task automatic parity_word(input logic [DW-1:0] w, input logic pbit);
        int k = 0, bd;
        wait_idle();
        bd = done_cnt;
        load_data  = w;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        while (!parity_phase && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("par_beat_index", k, DW);
        chk("par_ser_bit", ser_bit, pbit);
        chk("par_ser_last", ser_last, 1);
        chk("par_sel", sel, MSB ? 0 : DW - 1);
        wait_done(bd);
    endtask
`endif

    initial begin
        int lat, t1, a0, k;
        rst = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        step_en    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_a", a, 0);
        chk("rst_sel", sel, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_load_ready", load_ready, 1);

        send_word(8'b10101010, 0, 0, lat);
        chk("latency_plain", lat, DW + 1 + PAR);

        send_word(8'b11001100, 3, 3, lat);
        chk("latency_stall", lat, DW + 1 + PAR + 3);

        // continuous load_valid: words accepted with one mandatory IDLE cycle between
        wait_idle();
        a0 = acc_cnt;
        load_data  = 8'hF0;
        load_valid = 1'b1;
        k = 0;
        while (acc_cnt < a0 + 1 && k < 50) begin @(posedge clk); #1; k++; end
        t1 = acc_cyc;
        load_data = 8'h0F;
        k = 0;
        while (acc_cnt < a0 + 2 && k < 50) begin @(posedge clk); #1; k++; end
        chk("b2b_gap", acc_cyc - t1, DW + 1 + PAR);
        load_valid = 1'b0;
        wait_idle();

        // reset mid-word, released with load_valid already high
        load_data  = 8'hFF;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        k = 0;
        while (!(ser_valid && sel == SW'(5)) && k < 50) begin @(posedge clk); #1; k++; end
        #2 rst = 1'b1;
        #1;
        chk("abort_a", a, 0);
        chk("abort_sel", sel, 0);
        chk("abort_ser_valid", ser_valid, 0);
        chk("abort_ser_last", ser_last, 0);
        chk("abort_done", done, 0);
        load_data  = 8'h5A;
        load_valid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_edge_accept_valid", ser_valid, 1);
        chk("first_edge_accept_a", a, 8'h5A);
        load_valid = 1'b0;
        wait_idle();

`ifdef SER_PARITY_EN
        parity_word(8'b00000111, 1'b1);
        parity_word(8'b00000011, 1'b0);
`endif

        // random traffic with random stalls
        a0 = acc_cnt;
        k  = 0;
        while (acc_cnt < a0 + 40 && k < 5000) begin
            step_en    = ($urandom_range(0, 3) != 0);
            load_valid = ($urandom_range(0, 1) != 0);
            load_data  = DW'($urandom);
            @(posedge clk); #1;
            k++;
        end
        if (k >= 5000) chk("random_timeout", 1, 0);
        load_valid = 1'b0;
        step_en    = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
